thermo_alarm: RTL and testbench
===============================

THERMO_ALARM -- requirements
Module: thermo_alarm

Interface
REQ-001 SHALL provide parameter N, default 63: thermometer input width in segments.
REQ-002 SHALL provide parameter W, default 6: binary output width, with legal range W >= clog2(N+1).
REQ-003 SHALL provide parameter LOW_THR, default 10: alarm threshold; reading < LOW_THR is "low".
REQ-004 SHALL provide parameter HYST, default 2: clear threshold offset; reading >= LOW_THR+HYST is "clear".
REQ-005 SHALL provide parameter DEBOUNCE, default 4: consecutive qualifying samples needed to change alarm state; legal range >= 1.
REQ-006 SHALL provide parameter TONE_DIV, default 1000: speaker half-period in clk cycles; legal range >= 1.
REQ-007 SHALL provide port clk, input, 1 bit: single clock; all state on rising edge.
REQ-008 SHALL provide port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL provide port termometre, input, N bits: thermometer code; bit 0 is the lowest segment.
REQ-010 SHALL provide port sample_en, input, 1 bit: capture termometre on this cycle.
REQ-011 SHALL provide port binary, output, W bits: registered encoded reading.
REQ-012 SHALL provide port valid, output, 1 bit: one-cycle pulse when binary updates.
REQ-013 SHALL provide port bubble_err, output, 1 bit: last sample was non-contiguous; registered with binary.
REQ-014 SHALL provide port alarm, output, 1 bit: debounced low-reading alarm.
REQ-015 SHALL provide port speaker, output, 1 bit: square-wave tone while alarm=1.

Function
REQ-016 Encoding SHALL be: binary = (index of highest set bit)+1; all-zero input gives 0; all-ones input gives N.
REQ-017 bubble_err SHALL be 1 when any 0 lies below the highest set bit (e.g. 0b1011); binary still follows REQ-016.
REQ-018 Latency SHALL be one cycle: sample_en=1 at edge k gives binary, bubble_err and valid=1 visible after edge k+1.
REQ-019 valid SHALL be 0 in every cycle after an edge where sample_en was 0; binary and bubble_err SHALL hold.
REQ-020 Each update with valid=1 SHALL be classified as low, clear, or mid (LOW_THR <= binary < LOW_THR+HYST).
REQ-021 Updates with bubble_err=1 SHALL be ignored by the FSM: counter held, no state change.
REQ-022 FSM SHALL have states NORMAL (alarm=0), PEND_LOW (alarm=0), ALARM (alarm=1), PEND_CLR (alarm=1).
REQ-023 NORMAL SHALL go to PEND_LOW on a low update with cnt=1; if DEBOUNCE=1 it SHALL go directly to ALARM.
REQ-024 PEND_LOW: each low update SHALL increment cnt; at cnt=DEBOUNCE it SHALL go to ALARM; a mid or clear update SHALL return to NORMAL with cnt=0.
REQ-025 ALARM SHALL go to PEND_CLR on a clear update with cnt=1, or directly to NORMAL if DEBOUNCE=1; low and mid updates SHALL stay in ALARM.
REQ-026 PEND_CLR: each clear update SHALL increment cnt; at cnt=DEBOUNCE it SHALL go to NORMAL; a low or mid update SHALL return to ALARM with cnt=0.
REQ-027 alarm SHALL be a registered decode of state; it changes on the edge after the qualifying update's valid cycle.
REQ-028 Tone divider SHALL run only while alarm=1: it counts 0..TONE_DIV-1 and toggles speaker at wrap.
REQ-029 speaker SHALL start at 0, with the first toggle TONE_DIV cycles after alarm rises.
REQ-030 When alarm falls, speaker and the divider SHALL go to 0 on the same edge.
REQ-031 sample_en held high SHALL produce one update per cycle, with no loss.

Reset
REQ-032 rst_n=0 at a rising edge SHALL set binary=0, valid=0, bubble_err=0, alarm=0, speaker=0, state=NORMAL, cnt=0 and divider=0.
REQ-033 Reset SHALL override sample_en in the same cycle, including mid-debounce and mid-tone; the first capture SHALL occur on the first edge with rst_n=1 and sample_en=1.

Verification (N=63, LOW_THR=10, HYST=2, DEBOUNCE=4, TONE_DIV=4)
REQ-034 Bench SHALL cover encoding: sample 0x0, 0x7FF, all-ones, 0b1011 -> binary 0, 11, 63, 4; bubble_err 0, 0, 0, 1; each one cycle after sample_en.
REQ-035 Bench SHALL cover alarm entry: 4 consecutive samples of binary 5 -> alarm=1 after the 4th; 3 samples then one of binary 10 -> alarm stays 0.
REQ-036 Bench SHALL cover hysteresis: in ALARM, 4 samples of binary 11 -> alarm stays 1; then 4 samples of binary 12 -> alarm=0, speaker=0 on that edge.
REQ-037 Bench SHALL cover tone: alarm held -> speaker toggles every 4 cycles, first rising edge 4 cycles after alarm rises.
REQ-038 Bench SHALL cover bubbles: low, bubble, low, low, low -> alarm=1 after the 5th sample, since the bubble is not counted.
REQ-039 Bench SHALL cover reset: rst_n=0 during PEND_LOW at cnt=3 and during tone -> all outputs 0; one low sample afterwards does not raise alarm.

Source files
------------

// File: rtl/thermo_alarm_if.sv
// Bundles the thermometer sample input and the encoded/alarm outputs of thermo_alarm.
interface thermo_alarm_if #(
    parameter int N = 63,
    parameter int W = 6
);
    logic [N-1:0] termometre;
    logic         sample_en;
    logic [W-1:0] binary;
    logic         valid;
    logic         bubble_err;
    logic         alarm;
    logic         speaker;

    // Sensor / test side: drives samples, observes results
    modport master (
        output termometre, sample_en,
        input  binary, valid, bubble_err, alarm, speaker
    );

    // Alarm block side
    modport slave (
        input  termometre, sample_en,
        output binary, valid, bubble_err, alarm, speaker
    );
endinterface

// File: rtl/thermo_alarm.sv
// Thermometer-code encoder with bubble detection, debounced low-reading alarm
// with hysteresis, and a square-wave speaker tone generated while the alarm is set.
module thermo_alarm #(
    parameter int N        = 63,
    parameter int W        = 6,
    parameter int LOW_THR  = 10,
    parameter int HYST     = 2,
    parameter int DEBOUNCE = 4,
    parameter int TONE_DIV = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    thermo_alarm_if.slave bus
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int DW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);
    localparam int unsigned LOW_U = LOW_THR;
    localparam int unsigned CLR_U = LOW_THR + HYST;

    typedef enum logic [1:0] {
        S_NORMAL   = 2'd0,
        S_PEND_LOW = 2'd1,
        S_ALARM    = 2'd2,
        S_PEND_CLR = 2'd3
    } state_t;

    logic [W-1:0]  enc;
    logic          enc_bub;
    logic          seen;
    logic [W-1:0]  binary_q, binary_d;
    logic          bubble_q, bubble_d;
    logic          valid_q, valid_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          alarm_q, alarm_d;
    logic [DW-1:0] div_q, div_d;
    logic          speaker_q, speaker_d;
    logic          upd, is_low, is_clr;

    // Priority-encode the highest set segment; any zero below it is a bubble
    always_comb begin
        enc     = '0;
        enc_bub = 1'b0;
        seen    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.termometre[i]) begin
                if (!seen) enc = W'(i + 1);
                seen = 1'b1;
            end else if (seen) begin
                enc_bub = 1'b1;
            end
        end
    end

    // Capture stage: load a new reading on sample_en, otherwise hold it
    always_comb begin
        binary_d = binary_q;
        bubble_d = bubble_q;
        valid_d  = bus.sample_en;
        if (bus.sample_en) begin
            binary_d = enc;
            bubble_d = enc_bub;
        end
    end

    // Capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            binary_q <= '0;
            bubble_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            binary_q <= binary_d;
            bubble_q <= bubble_d;
            valid_q  <= valid_d;
        end
    end

    // Bubbled readings never reach the debounce logic
    assign upd    = valid_q & ~bubble_q;
    assign is_low = 32'(binary_q) <  LOW_U;
    assign is_clr = 32'(binary_q) >= CLR_U;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: count consecutive qualifying updates; any other update restarts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (upd) begin
            case (state_q)
                S_NORMAL: begin
                    if (is_low) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_ALARM;
                        end else begin
                            state_d = S_PEND_LOW;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                S_PEND_LOW: begin
                    if (is_low) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_ALARM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = S_NORMAL;
                        cnt_d   = '0;
                    end
                end
                S_ALARM: begin
                    if (is_clr) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_NORMAL;
                        end else begin
                            state_d = S_PEND_CLR;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                S_PEND_CLR: begin
                    if (is_clr) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_NORMAL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = S_ALARM;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM outputs: alarm decode of next state, and tone divider that only runs while alarm stays high
    always_comb begin
        alarm_d   = (state_d == S_ALARM) || (state_d == S_PEND_CLR);
        div_d     = '0;
        speaker_d = 1'b0;
        if (alarm_q && alarm_d) begin
            if (div_q == DIV_LAST) begin
                div_d     = '0;
                speaker_d = ~speaker_q;
            end else begin
                div_d     = div_q + DW'(1);
                speaker_d = speaker_q;
            end
        end
    end

    // Alarm and tone registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_q   <= 1'b0;
            div_q     <= '0;
            speaker_q <= 1'b0;
        end else begin
            alarm_q   <= alarm_d;
            div_q     <= div_d;
            speaker_q <= speaker_d;
        end
    end

    assign bus.binary     = binary_q;
    assign bus.valid      = valid_q;
    assign bus.bubble_err = bubble_q;
    assign bus.alarm      = alarm_q;
    assign bus.speaker    = speaker_q;
endmodule

// File: tb/tb_thermo_alarm.sv
// Bench for thermo_alarm: encoding table, alarm/hysteresis/tone/bubble/reset
// sequences, and randomized traffic checked against a reading-level model.
module tb_thermo_alarm;
    localparam int N = 63;
    localparam int W = 6;
    localparam int LOW_THR = 10;
    localparam int HYST = 2;
    localparam int DEB = 4;
    localparam int TDIV = 4;

    localparam logic [62:0] T5  = 63'h1F;
    localparam logic [62:0] T10 = 63'h3FF;
    localparam logic [62:0] T11 = 63'h7FF;
    localparam logic [62:0] T12 = 63'hFFF;
    localparam logic [62:0] TBB = 63'b1011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    thermo_alarm_if #(.N(N), .W(W)) bus ();

    thermo_alarm #(
        .N(N), .W(W), .LOW_THR(LOW_THR), .HYST(HYST),
        .DEBOUNCE(DEB), .TONE_DIV(TDIV)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: last visible reading, alarm flag, run of qualifying readings,
    // and edges elapsed since the alarm rose.
    int m_bin = 0;
    bit m_bub = 0;
    bit m_val = 0;
    bit m_alarm = 0;
    int m_run = 0;
    int m_t = 0;
    bit m_spk = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [62:0] th, input bit en, input bit rst);
        bit      old_alarm;
        bit      low, clr;
        logic [63:0] v;
        bus.termometre = th;
        bus.sample_en  = en;
        rst_n          = !rst;
        @(posedge clk);
        if (rst) begin
            m_bin = 0; m_bub = 0; m_val = 0;
            m_alarm = 0; m_run = 0; m_t = 0; m_spk = 0;
        end else begin
            old_alarm = m_alarm;
            if (m_val && !m_bub) begin
                low = (m_bin < LOW_THR);
                clr = (m_bin >= LOW_THR + HYST);
                if (!m_alarm) m_run = low ? m_run + 1 : 0;
                else          m_run = clr ? m_run + 1 : 0;
                if (m_run == DEB) begin
                    m_alarm = !m_alarm;
                    m_run   = 0;
                end
            end
            if (old_alarm && m_alarm) m_t++;
            else                      m_t = 0;
            m_spk = (old_alarm && m_alarm) ? (((m_t / TDIV) % 2) == 1) : 1'b0;
            m_val = en;
            if (en) begin
                v     = {1'b0, th};
                m_bin = $clog2(v + 64'd1);
                m_bub = (v != ((64'd1 << m_bin) - 64'd1));
            end
        end
        #1;
        chk("binary",     int'(bus.binary),     m_bin);
        chk("valid",      int'(bus.valid),      int'(m_val));
        chk("bubble_err", int'(bus.bubble_err), int'(m_bub));
        chk("alarm",      int'(bus.alarm),      int'(m_alarm));
        chk("speaker",    int'(bus.speaker),    int'(m_spk));
    endtask

    task automatic samp(input logic [62:0] th);
        tick(th, 1'b1, 1'b0);
    endtask

    task automatic idle();
        tick('0, 1'b0, 1'b0);
    endtask

    // Return to NORMAL with an empty run
    task automatic normalize();
        for (int i = 0; i < DEB; i++) samp(T12);
        idle();
        idle();
    endtask

    typedef struct {
        logic [62:0] th;
        bit          en;
        int          exp_bin;
        bit          exp_bub;
        bit          exp_val;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [62:0] r;
        int          lvl;
        vt[0] = '{63'h0,                1'b1, 0,  1'b0, 1'b1};
        vt[1] = '{T11,                  1'b1, 11, 1'b0, 1'b1};
        vt[2] = '{63'h7FFF_FFFF_FFFF_FFFF, 1'b1, 63, 1'b0, 1'b1};
        vt[3] = '{TBB,                  1'b1, 4,  1'b1, 1'b1};
        vt[4] = '{T5,                   1'b0, 4,  1'b1, 1'b0};
        vt[5] = '{63'h1,                1'b1, 1,  1'b0, 1'b1};

        bus.termometre = '0;
        bus.sample_en  = 1'b1;

        // Reset state, with sample_en asserted to show reset wins
        tick(T12, 1'b1, 1'b1);
        tick(T12, 1'b1, 1'b1);
        chk("rst_binary", int'(bus.binary), 0);
        chk("rst_valid",  int'(bus.valid),  0);
        chk("rst_alarm",  int'(bus.alarm),  0);

        // Encoding table
        foreach (vt[i]) begin
            tick(vt[i].th, vt[i].en, 1'b0);
            chk("tbl_binary", int'(bus.binary),     vt[i].exp_bin);
            chk("tbl_bubble", int'(bus.bubble_err), int'(vt[i].exp_bub));
            chk("tbl_valid",  int'(bus.valid),      int'(vt[i].exp_val));
        end
        normalize();

        // Three lows then a mid reading: no alarm
        for (int i = 0; i < 3; i++) samp(T5);
        samp(T10);
        idle(); idle();
        chk("entry_interrupted", int'(bus.alarm), 0);

        // Four lows: alarm on the edge after the fourth reading's valid cycle
        for (int i = 0; i < 4; i++) samp(T5);
        chk("entry_pre", int'(bus.alarm), 0);
        idle();
        chk("entry_alarm", int'(bus.alarm), 1);
        chk("entry_spk0",  int'(bus.speaker), 0);

        // Tone: speaker flips every TDIV edges, first rise TDIV edges after alarm
        for (int k = 1; k <= 10; k++) begin
            idle();
            chk("tone", int'(bus.speaker), (k / TDIV) % 2);
        end

        // Hysteresis: mid readings keep the alarm; clear readings drop it
        for (int i = 0; i < 4; i++) samp(T11);
        idle();
        chk("hyst_hold", int'(bus.alarm), 1);
        for (int i = 0; i < 4; i++) samp(T12);
        chk("hyst_pre", int'(bus.alarm), 1);
        idle();
        chk("hyst_clear", int'(bus.alarm),   0);
        chk("hyst_spk",   int'(bus.speaker), 0);
        normalize();

        // Bubble in the middle of a low run is skipped, not counted or reset
        samp(T5); samp(TBB); samp(T5); samp(T5); samp(T5);
        chk("bubble_pre", int'(bus.alarm), 0);
        idle();
        chk("bubble_alarm", int'(bus.alarm), 1);
        normalize();

        // Reset in PEND_LOW at cnt=3
        for (int i = 0; i < 3; i++) samp(T5);
        idle();
        tick(T5, 1'b1, 1'b1);
        chk("rst1_alarm", int'(bus.alarm), 0);
        chk("rst1_valid", int'(bus.valid), 0);
        chk("rst1_bin",   int'(bus.binary), 0);
        samp(T5); idle(); idle();
        chk("rst1_after", int'(bus.alarm), 0);
        normalize();

        // Reset during tone
        for (int i = 0; i < 4; i++) samp(T5);
        for (int i = 0; i < 6; i++) idle();
        chk("rst2_pre_spk", int'(bus.speaker), 1);
        tick(T5, 1'b1, 1'b1);
        chk("rst2_alarm", int'(bus.alarm),   0);
        chk("rst2_spk",   int'(bus.speaker), 0);
        samp(T5); idle(); idle();
        chk("rst2_after", int'(bus.alarm), 0);

        // Randomized traffic around the thresholds
        for (int n = 0; n < 3000; n++) begin
            lvl = ($urandom % 8 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 16));
            r = (lvl >= 63) ? 63'h7FFF_FFFF_FFFF_FFFF : 63'((64'd1 << lvl) - 64'd1);
            if (lvl >= 2 && ($urandom % 10 == 0))
                r[$urandom_range(0, lvl - 2)] = 1'b0;
            tick(r, ($urandom % 4) != 0, ($urandom % 300) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
